// File: rtl/twos_complement_pkg.sv
// Shared constants for the two's-complement negator: FSM encoding and default width.
package twos_complement_pkg;

  localparam int unsigned DEFAULT_WIDTH = 5;
  localparam int unsigned STATE_W       = 2;

  localparam int unsigned ST_IDLE   = 0;
  localparam int unsigned ST_INVERT = 1;
  localparam int unsigned ST_INCR   = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'(ST_IDLE),
    INVERT = 2'(ST_INVERT),
    INCR   = 2'(ST_INCR)
  } state_e;

endpackage

// File: rtl/twos_comp_incr.sv
// Incrementer stage holding the inverted operand; parallel by default, bit-serial
// (one bit per cycle, LSB first) when TWOS_COMP_SERIAL_INCR_EN is defined.
module twos_comp_incr
  import twos_complement_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_sum_c,
  output logic             o_last_c
);

  logic [WIDTH-1:0] r_work;

`ifdef TWOS_COMP_SERIAL_INCR_EN
  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] w_work_nxt;

  // Current bit absorbs the carry; the final bit is folded into the result output.
  always_comb begin
    w_work_nxt        = r_work;
    w_work_nxt[r_cnt] = r_work[r_cnt] ^ r_carry;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_work  <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
    end else if (i_load) begin
      r_work  <= i_data;
      r_cnt   <= '0;
      r_carry <= 1'b1;
    end else if (i_en) begin
      r_work  <= w_work_nxt;
      r_carry <= r_carry & r_work[r_cnt];
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign o_sum_c  = w_work_nxt;
  assign o_last_c = i_en && (r_cnt == CNT_W'(WIDTH - 1));
`else
  always_ff @(posedge clock) begin
    if (reset) begin
      r_work <= '0;
    end else if (i_load) begin
      r_work <= i_data;
    end
  end

  // Carry-out is dropped: arithmetic wraps modulo 2^WIDTH.
  assign o_sum_c  = r_work + WIDTH'(1);
  assign o_last_c = i_en;
`endif

endmodule

// File: rtl/twos_complement_mod.sv
// Multi-cycle two's-complement negator with pulse handshake (IDLE -> INVERT -> INCR).
// Build option: TWOS_COMP_SERIAL_INCR_EN selects the bit-serial incrementer.
module twos_complement_mod
  import twos_complement_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_tog,
  input  logic             in_tog_valid_pulse,
  output logic             mod_busy,
  output logic [WIDTH-1:0] out_tog,
  output logic             out_tog_valid_pulse
);

  state_e           r_state;
  logic [WIDTH-1:0] r_captured;
  logic [WIDTH-1:0] r_out;
  logic             r_valid;
  logic             r_busy;

  state_e           w_state_nxt;
  logic [WIDTH-1:0] w_captured_nxt;
  logic [WIDTH-1:0] w_out_nxt;
  logic             w_valid_nxt;
  logic             w_busy_nxt;
  logic             w_load;
  logic             w_en;
  logic [WIDTH-1:0] w_sum;
  logic             w_last;

  twos_comp_incr #(
    .WIDTH (WIDTH)
  ) u_incr (
    .clock    (clock),
    .reset    (reset),
    .i_load   (w_load),
    .i_data   (~r_captured),
    .i_en     (w_en),
    .o_sum_c  (w_sum),
    .o_last_c (w_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_captured <= '0;
      r_out      <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_captured <= w_captured_nxt;
      r_out      <= w_out_nxt;
      r_valid    <= w_valid_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Requests are only sampled in IDLE, so a pulse while busy is dropped.
  always_comb begin
    w_state_nxt    = r_state;
    w_captured_nxt = r_captured;
    w_out_nxt      = r_out;
    w_valid_nxt    = 1'b0;
    w_busy_nxt     = r_busy;
    w_load         = 1'b0;
    w_en           = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_tog_valid_pulse) begin
          w_captured_nxt = in_tog;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = INVERT;
        end
      end
      INVERT: begin
        w_load      = 1'b1;
        w_state_nxt = INCR;
      end
      INCR: begin
        w_en = 1'b1;
        if (w_last) begin
          w_out_nxt   = w_sum;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign mod_busy            = r_busy;
  assign out_tog             = r_out;
  assign out_tog_valid_pulse = r_valid;

endmodule

// File: tb/tb_twos_complement_mod.sv
// Directed bench for twos_complement_mod: 5-bit and 10-bit instances side by side.
module tb_twos_complement_mod;

`ifdef TWOS_COMP_SERIAL_INCR_EN
  localparam int LAT5  = 7;
  localparam int LAT10 = 12;
`else
  localparam int LAT5  = 3;
  localparam int LAT10 = 3;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] in5;
  logic       v5;
  logic       busy5;
  logic [4:0] out5;
  logic       done5;
  logic [9:0] in10;
  logic       v10;
  logic       busy10;
  logic [9:0] out10;
  logic       done10;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  twos_complement_mod u_dut5 (
    .clock               (clock),
    .reset               (reset),
    .in_tog              (in5),
    .in_tog_valid_pulse  (v5),
    .mod_busy            (busy5),
    .out_tog             (out5),
    .out_tog_valid_pulse (done5)
  );

  twos_complement_mod #(4'd10) u_dut10 (
    .clock               (clock),
    .reset               (reset),
    .in_tog              (in10),
    .in_tog_valid_pulse  (v10),
    .mod_busy            (busy10),
    .out_tog             (out10),
    .out_tog_valid_pulse (done10)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a 5-bit request, then verify busy window, single-cycle done and held result.
  task automatic run5(input string tag, input logic [4:0] data, input logic [4:0] exp);
    in5 = data;
    v5  = 1'b1;
    step();
    v5  = 1'b0;
    check({tag, " busy"}, 10'(busy5), 10'd1);
    for (int i = 0; i < LAT5 - 2; i++) begin
      step();
      check({tag, " early_done"}, 10'(done5), 10'd0);
    end
    step();
    check({tag, " done"}, 10'(done5), 10'd1);
    check({tag, " out"}, 10'(out5), 10'(exp));
    check({tag, " busy_fall"}, 10'(busy5), 10'd0);
    step();
    check({tag, " done_1cyc"}, 10'(done5), 10'd0);
    check({tag, " out_hold"}, 10'(out5), 10'(exp));
  endtask

  task automatic run10(input string tag, input logic [9:0] data, input logic [9:0] exp);
    in10 = data;
    v10  = 1'b1;
    step();
    v10  = 1'b0;
    check({tag, " busy"}, 10'(busy10), 10'd1);
    for (int i = 0; i < LAT10 - 2; i++) step();
    step();
    check({tag, " done"}, 10'(done10), 10'd1);
    check({tag, " out"}, out10, exp);
    step();
    check({tag, " done_1cyc"}, 10'(done10), 10'd0);
  endtask

  initial begin
    int pulses;
    reset = 1'b1;
    in5   = '0;
    v5    = 1'b0;
    in10  = '0;
    v10   = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("rst busy5", 10'(busy5), 10'd0);
    check("rst out5", 10'(out5), 10'd0);
    check("rst done5", 10'(done5), 10'd0);
    check("rst out10", out10, 10'd0);
    check("rst busy10", 10'(busy10), 10'd0);

    run5("w5 3", 5'b00011, 5'b11101);
    run5("w5 zero", 5'b00000, 5'b00000);
    run5("w5 minneg", 5'b10000, 5'b10000);
    run5("w5 allones", 5'b11111, 5'b00001);
    run5("w5 9", 5'b01001, 5'b10111);

    run10("w10 one", 10'h001, 10'h3FF);
    run10("w10 allones", 10'h3FF, 10'h001);
    run10("w10 minneg", 10'h200, 10'h200);

    // Second pulse while busy: ignored, exactly one done carrying the first result.
    in5 = 5'b00011;
    v5  = 1'b1;
    step();
    in5 = 5'b00111;
    step();
    v5  = 1'b0;
    in5 = 5'b00000;
    pulses = 0;
    for (int i = 0; i < LAT5 + 4; i++) begin
      if (done5) begin
        pulses++;
        check("busy_ign out", 10'(out5), 10'(5'b11101));
      end
      step();
    end
    check("busy_ign pulses", 10'(pulses), 10'd1);
    check("busy_ign idle", 10'(busy5), 10'd0);

    // Request presented in the done cycle is accepted.
    in5 = 5'b00011;
    v5  = 1'b1;
    step();
    v5  = 1'b0;
    for (int i = 0; i < LAT5 - 1; i++) step();
    check("b2b first done", 10'(done5), 10'd1);
    check("b2b first out", 10'(out5), 10'(5'b11101));
    in5 = 5'b00001;
    v5  = 1'b1;
    step();
    v5  = 1'b0;
    check("b2b accept busy", 10'(busy5), 10'd1);
    check("b2b out held", 10'(out5), 10'(5'b11101));
    for (int i = 0; i < LAT5 - 1; i++) step();
    check("b2b second done", 10'(done5), 10'd1);
    check("b2b second out", 10'(out5), 10'(5'b11111));
    step();

    // Reset while the request sits in INVERT aborts it.
    in5 = 5'b00101;
    v5  = 1'b1;
    step();
    v5    = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort busy", 10'(busy5), 10'd0);
    check("abort out", 10'(out5), 10'd0);
    pulses = 0;
    for (int i = 0; i < LAT5 + 3; i++) begin
      if (done5) pulses++;
      step();
    end
    check("abort no_done", 10'(pulses), 10'd0);
    check("abort out_after", 10'(out5), 10'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
